// File: rtl/raster_pkg.sv
// Shared raster definitions: sweep FSM state type and default frame geometry.
package raster_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_state_t;

    localparam int unsigned FRAME_WIDTH  = 320;
    localparam int unsigned FRAME_HEIGHT = 180;
    localparam int unsigned FRAME_HW     = 9;
    localparam int unsigned FRAME_VW     = 8;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; at_max flags the terminal count.
module wrap_counter #(
    parameter int unsigned MAX = 1,
    parameter int unsigned W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_W = W'(MAX);

    assign at_max = (count == MAX_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_max ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/pixel_sweep.sv
// Raster-order pixel coordinate generator with stall-driven hold and done pulse.
module pixel_sweep
    import raster_pkg::*;
#(
    parameter int unsigned WIDTH  = FRAME_WIDTH,
    parameter int unsigned HEIGHT = FRAME_HEIGHT,
    parameter int unsigned HW     = FRAME_HW,
    parameter int unsigned VW     = FRAME_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          valid,
    output logic          last,
    output logic          busy,
    output logic          done
);

    localparam logic [HW-1:0] HMAX       = HW'(WIDTH - 1);
    localparam logic [VW-1:0] VMAX       = VW'(HEIGHT - 1);
    localparam logic          FIRST_LAST = (WIDTH == 1) && (HEIGHT == 1);

    sweep_state_t  state;
    logic          accept;
    logic          col_at_max;
    logic          row_at_max;
    logic          cnt_clr;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          next_last;

    assign accept  = valid && !stall;
    assign cnt_clr = (state != SWEEP);

    wrap_counter #(
        .MAX (WIDTH - 1),
        .W   (HW)
    ) u_col (
        .clk    (clk),
        .rst    (rst),
        .en     (accept),
        .clr    (cnt_clr),
        .count  (hcount),
        .at_max (col_at_max)
    );

    wrap_counter #(
        .MAX (HEIGHT - 1),
        .W   (VW)
    ) u_row (
        .clk    (clk),
        .rst    (rst),
        .en     (accept && col_at_max),
        .clr    (cnt_clr),
        .count  (vcount),
        .at_max (row_at_max)
    );

    // Coordinates of the pixel that follows the current one; only used on
    // non-final acceptances, so the row increment never overflows.
    always_comb begin
        h_next    = col_at_max ? '0 : hcount + HW'(1);
        v_next    = col_at_max ? vcount + VW'(1) : vcount;
        next_last = (h_next == HMAX) && (v_next == VMAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            valid <= 1'b0;
            last  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= SWEEP;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                        last  <= FIRST_LAST;
                    end
                end
                SWEEP: begin
                    if (accept) begin
                        if (last) begin
                            state <= DONE;
                            valid <= 1'b0;
                            last  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            last <= next_last;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    last  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // row_at_max is implied by last; kept visible for the row counter only.
    logic unused_row_at_max;
    assign unused_row_at_max = row_at_max;

endmodule
